// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings and datapath width for the MIPS32 execute stage.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MEM_LO = 6'h20;
    localparam logic [5:0] OP_MEM_HI = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // Signed less-than on two XLEN words, as a 0/1 word.
    function automatic logic [XLEN-1:0] slt_signed(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/mips_hilo.sv
// HI/LO register pair updated by MULT/MULTU/DIV/DIVU/MTHI/MTLO; divide by zero leaves both unchanged.
module mips_hilo
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      i_op,
    input  logic [5:0]      i_funct,
    input  logic [XLEN-1:0] i_rs,
    input  logic [XLEN-1:0] i_rt,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [2*XLEN-1:0] w_prod_s;
    logic [2*XLEN-1:0] w_prod_u;
    logic [XLEN-1:0]   w_sq;
    logic [XLEN-1:0]   w_sr;
    logic [XLEN-1:0]   w_uq;
    logic [XLEN-1:0]   w_ur;
    logic [XLEN-1:0]   w_hi_nxt;
    logic [XLEN-1:0]   w_lo_nxt;
    logic              w_div0;

    assign w_prod_s = $unsigned($signed({{XLEN{i_rs[XLEN-1]}}, i_rs}) * $signed({{XLEN{i_rt[XLEN-1]}}, i_rt}));
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};
    assign w_div0   = (i_rt == 32'd0);
    // Operands are forced safe on divide by zero; the result is discarded in that case anyway.
    assign w_sq     = w_div0 ? 32'd0 : $unsigned($signed(i_rs) / $signed(i_rt));
    assign w_sr     = w_div0 ? 32'd0 : $unsigned($signed(i_rs) % $signed(i_rt));
    assign w_uq     = w_div0 ? 32'd0 : (i_rs / i_rt);
    assign w_ur     = w_div0 ? 32'd0 : (i_rs % i_rt);

    // Next-value selection for HI/LO; holds by default.
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (i_op == OP_RTYPE) begin
            case (i_funct)
                F_MTHI:  w_hi_nxt = i_rs;
                F_MTLO:  w_lo_nxt = i_rs;
                F_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                F_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                F_DIV: begin
                    if (!w_div0) begin
                        w_hi_nxt = w_sr;
                        w_lo_nxt = w_sq;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end
                F_DIVU: begin
                    if (!w_div0) begin
                        w_hi_nxt = w_ur;
                        w_lo_nxt = w_uq;
                    end else begin
                        w_hi_nxt = r_hi;
                        w_lo_nxt = r_lo;
                    end
                end
                default: begin
                    w_hi_nxt = r_hi;
                    w_lo_nxt = r_lo;
                end
            endcase
        end else begin
            w_hi_nxt = r_hi;
            w_lo_nxt = r_lo;
        end
    end

    // HI/LO state; synchronous active-low reset overrides any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mips_ex_stage.sv
// Single-cycle MIPS32 execute stage: combinational ALU/shift result and next-PC selection, plus HI/LO.
module mips_ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] nextPC,
    input  logic [WIDTH-1:0] Ins,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    input  logic [WIDTH-1:0] Ed32,
    output logic [WIDTH-1:0] newPC,
    output logic [WIDTH-1:0] Result
);

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic [4:0]       w_shamt;
    logic [4:0]       w_vshamt;
    logic [XLEN-1:0]  w_hi;
    logic [XLEN-1:0]  w_lo;
    logic [XLEN-1:0]  w_jtarget;
    logic [XLEN-1:0]  w_btarget;
    logic [XLEN-1:0]  w_zimm;
    logic [XLEN-1:0]  w_result;
    logic [XLEN-1:0]  w_newpc;

    assign w_op      = Ins[31:26];
    assign w_funct   = Ins[5:0];
    assign w_shamt   = Ins[10:6];
    assign w_vshamt  = Rdata1[4:0];
    assign w_jtarget = {nextPC[31:28], Ins[25:0], 2'b00};
    assign w_btarget = nextPC + {Ed32[29:0], 2'b00};
    assign w_zimm    = {16'd0, Ed32[15:0]};

    mips_hilo u_hilo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_op    (w_op),
        .i_funct (w_funct),
        .i_rs    (Rdata1),
        .i_rt    (Rdata2),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    // Result and next-PC selection by opcode and funct.
    always_comb begin
        w_result = 32'd0;
        w_newpc  = nextPC;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    F_ADD, F_ADDU: w_result = Rdata1 + Rdata2;
                    F_SUB, F_SUBU: w_result = Rdata1 - Rdata2;
                    F_AND:   w_result = Rdata1 & Rdata2;
                    F_OR:    w_result = Rdata1 | Rdata2;
                    F_XOR:   w_result = Rdata1 ^ Rdata2;
                    F_NOR:   w_result = ~(Rdata1 | Rdata2);
                    F_SLT:   w_result = slt_signed(Rdata1, Rdata2);
                    F_SLTU:  w_result = (Rdata1 < Rdata2) ? 32'd1 : 32'd0;
                    F_SLL:   w_result = Rdata2 << w_shamt;
                    F_SRL:   w_result = Rdata2 >> w_shamt;
                    F_SRA:   w_result = $unsigned($signed(Rdata2) >>> w_shamt);
                    F_SLLV:  w_result = Rdata2 << w_vshamt;
                    F_SRLV:  w_result = Rdata2 >> w_vshamt;
                    F_SRAV:  w_result = $unsigned($signed(Rdata2) >>> w_vshamt);
                    F_MFHI:  w_result = w_hi;
                    F_MFLO:  w_result = w_lo;
                    F_JR:    w_newpc  = Rdata1;
                    F_JALR: begin
                        w_newpc  = Rdata1;
                        w_result = nextPC;
                    end
                    default: w_result = 32'd0;
                endcase
            end
            OP_J:     w_newpc = w_jtarget;
            OP_JAL: begin
                w_newpc  = w_jtarget;
                w_result = nextPC;
            end
            OP_BEQ:   w_newpc = (Rdata1 == Rdata2) ? w_btarget : nextPC;
            OP_BNE:   w_newpc = (Rdata1 != Rdata2) ? w_btarget : nextPC;
            OP_BLEZ:  w_newpc = (Rdata1[31] || (Rdata1 == 32'd0)) ? w_btarget : nextPC;
            OP_BGTZ:  w_newpc = (!Rdata1[31] && (Rdata1 != 32'd0)) ? w_btarget : nextPC;
            OP_ADDI, OP_ADDIU: w_result = Rdata1 + Ed32;
            OP_SLTI:  w_result = slt_signed(Rdata1, Ed32);
            OP_SLTIU: w_result = (Rdata1 < Ed32) ? 32'd1 : 32'd0;
            OP_ANDI:  w_result = Rdata1 & w_zimm;
            OP_ORI:   w_result = Rdata1 | w_zimm;
            OP_XORI:  w_result = Rdata1 ^ w_zimm;
            OP_LUI:   w_result = {Ins[15:0], 16'd0};
            default: begin
                if ((w_op >= OP_MEM_LO) && (w_op <= OP_MEM_HI)) begin
                    w_result = Rdata1 + Ed32;
                end else begin
                    w_result = 32'd0;
                end
            end
        endcase
    end

    assign Result = w_result;
    assign newPC  = w_newpc;

endmodule

// File: tb/tb_mips_ex_stage.sv
// Directed self-checking bench for mips_ex_stage with hand-computed expectations.
module tb_mips_ex_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] nextPC;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic [31:0] Ed32;
    logic [31:0] newPC;
    logic [31:0] Result;

    int total = 0;
    int bad   = 0;

    mips_ex_stage dut (
        .CLK    (CLK),
        .RST    (RST),
        .nextPC (nextPC),
        .Ins    (Ins),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .Ed32   (Ed32),
        .newPC  (newPC),
        .Result (Result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] rt(input logic [5:0] funct, input logic [4:0] shamt);
        return {6'd0, 5'd0, 5'd0, 5'd0, shamt, funct};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd0, 5'd0, imm};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] npc);
        Ins = ins; Rdata1 = a; Rdata2 = b; Ed32 = imm; nextPC = npc;
        #1;
    endtask

    task automatic clock_edge;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        drive(rt(6'h11, 5'd0), 32'hDEAD_BEEF, 32'd0, 32'd0, 32'h0000_0004);
        clock_edge();
        clock_edge();
        RST = 1'b1;
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'h0000_0004);
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", Result, 32'd0); end
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'h0000_0004);
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", Result, 32'd0); end
    endtask

    task automatic test_arith;
        logic [5:0]  fn  [5] = '{6'h20, 6'h22, 6'h23, 6'h27, 6'h3F};
        logic [31:0] a   [5] = '{32'd1, 32'd5, 32'd20, 32'd43, 32'd7};
        logic [31:0] b   [5] = '{32'd1, 32'd3, 32'd11, 32'd32, 32'd9};
        logic [31:0] exp [5] = '{32'd2, 32'd2, 32'd9, 32'hFFFF_FFD4, 32'd0};
        for (int i = 0; i < 5; i++) begin
            drive(rt(fn[i], 5'd0), a[i], b[i], 32'd0, 32'h0000_1004);
            total++;
            if (Result !== exp[i]) begin bad++; $display("FAIL arith_%0d got=%h exp=%h", i, Result, exp[i]); end
            total++;
            if (newPC !== 32'h0000_1004) begin bad++; $display("FAIL arith_pc_%0d got=%h exp=%h", i, newPC, 32'h0000_1004); end
        end
    endtask

    task automatic test_compare;
        logic [31:0] ins [6];
        logic [31:0] a   [6] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1};
        logic [31:0] b   [6] = '{32'd1, 32'd4, 32'd1, 32'd1, 32'd0, 32'd0};
        logic [31:0] imm [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd100, 32'd1};
        logic [31:0] exp [6] = '{32'd0, 32'd1, 32'd1, 32'd0, 32'd1, 32'd0};
        ins[0] = rt(6'h2A, 5'd0); ins[1] = rt(6'h2A, 5'd0); ins[2] = rt(6'h2A, 5'd0);
        ins[3] = rt(6'h2B, 5'd0); ins[4] = it(6'h0A, 16'd100); ins[5] = it(6'h0B, 16'd1);
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], a[i], b[i], imm[i], 32'h0000_0010);
            total++;
            if (Result !== exp[i]) begin bad++; $display("FAIL compare_%0d got=%h exp=%h", i, Result, exp[i]); end
        end
    endtask

    task automatic test_shift;
        drive(rt(6'h00, 5'd4), 32'd0, 32'd1, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd16) begin bad++; $display("FAIL sll got=%h exp=%h", Result, 32'd16); end
        drive(rt(6'h03, 5'd4), 32'd0, 32'h8000_0000, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h exp=%h", Result, 32'hF800_0000); end
        drive(rt(6'h06, 5'd0), 32'd4, 32'h8000_0000, 32'd0, 32'd0);
        total++;
        if (Result !== 32'h0800_0000) begin bad++; $display("FAIL srlv got=%h exp=%h", Result, 32'h0800_0000); end
        drive(rt(6'h07, 5'd0), 32'h0000_0024, 32'h8000_0000, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hF800_0000) begin bad++; $display("FAIL srav got=%h exp=%h", Result, 32'hF800_0000); end
    endtask

    task automatic test_itype;
        drive(it(6'h0F, 16'h1234), 32'd0, 32'd0, 32'h0000_1234, 32'd0);
        total++;
        if (Result !== 32'h1234_0000) begin bad++; $display("FAIL lui got=%h exp=%h", Result, 32'h1234_0000); end
        drive(it(6'h0C, 16'h8001), 32'hFFFF_FFFF, 32'd0, 32'hFFFF_8001, 32'd0);
        total++;
        if (Result !== 32'h0000_8001) begin bad++; $display("FAIL andi got=%h exp=%h", Result, 32'h0000_8001); end
        drive(it(6'h23, 16'hFFFC), 32'h0000_1000, 32'd0, 32'hFFFF_FFFC, 32'd0);
        total++;
        if (Result !== 32'h0000_0FFC) begin bad++; $display("FAIL lw_addr got=%h exp=%h", Result, 32'h0000_0FFC); end
        drive(it(6'h08, 16'hFFFF), 32'd10, 32'd0, 32'hFFFF_FFFF, 32'd0);
        total++;
        if (Result !== 32'd9) begin bad++; $display("FAIL addi got=%h exp=%h", Result, 32'd9); end
    endtask

    task automatic test_hilo;
        drive(rt(6'h18, 5'd0), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL mult_result got=%h exp=%h", Result, 32'd0); end
        clock_edge();
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=%h", Result, 32'hFFFF_FFFF); end
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h exp=%h", Result, 32'hFFFF_FFFE); end
        drive(rt(6'h19, 5'd0), 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd1) begin bad++; $display("FAIL multu_hi got=%h exp=%h", Result, 32'd1); end
        drive(rt(6'h1B, 5'd0), 32'd7, 32'd2, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd3) begin bad++; $display("FAIL divu_lo got=%h exp=%h", Result, 32'd3); end
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd1) begin bad++; $display("FAIL divu_hi got=%h exp=%h", Result, 32'd1); end
        drive(rt(6'h1A, 5'd0), 32'd99, 32'd0, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h1B, 5'd0), 32'd99, 32'd0, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd3) begin bad++; $display("FAIL div0_lo got=%h exp=%h", Result, 32'd3); end
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd1) begin bad++; $display("FAIL div0_hi got=%h exp=%h", Result, 32'd1); end
        drive(rt(6'h1A, 5'd0), 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=%h", Result, 32'hFFFF_FFFD); end
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=%h", Result, 32'hFFFF_FFFF); end
        drive(rt(6'h11, 5'd0), 32'hA5A5_0001, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL mthi_result got=%h exp=%h", Result, 32'd0); end
        clock_edge();
        drive(rt(6'h13, 5'd0), 32'h5A5A_0002, 32'd0, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h3E, 5'd0), 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0);
        clock_edge();
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'hA5A5_0001) begin bad++; $display("FAIL mthi got=%h exp=%h", Result, 32'hA5A5_0001); end
        drive(rt(6'h12, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'h5A5A_0002) begin bad++; $display("FAIL mtlo got=%h exp=%h", Result, 32'h5A5A_0002); end
        RST = 1'b0;
        drive(rt(6'h11, 5'd0), 32'h7777_7777, 32'd0, 32'd0, 32'd0);
        clock_edge();
        RST = 1'b1;
        drive(rt(6'h10, 5'd0), 32'd0, 32'd0, 32'd0, 32'd0);
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL rst_hi got=%h exp=%h", Result, 32'd0); end
    endtask

    task automatic test_jumps;
        drive({6'd2, 26'd64}, 32'd0, 32'd0, 32'd0, 32'h2000_04BD);
        total++;
        if (newPC !== 32'h2000_0100) begin bad++; $display("FAIL j_pc got=%h exp=%h", newPC, 32'h2000_0100); end
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL j_result got=%h exp=%h", Result, 32'd0); end
        drive({6'd3, 26'd128}, 32'd0, 32'd0, 32'd0, 32'h6000_0000);
        total++;
        if (newPC !== 32'h6000_0200) begin bad++; $display("FAIL jal_pc got=%h exp=%h", newPC, 32'h6000_0200); end
        total++;
        if (Result !== 32'h6000_0000) begin bad++; $display("FAIL jal_result got=%h exp=%h", Result, 32'h6000_0000); end
        drive(rt(6'h08, 5'd0), 32'd34, 32'd0, 32'd0, 32'h0000_0040);
        total++;
        if (newPC !== 32'd34) begin bad++; $display("FAIL jr_pc got=%h exp=%h", newPC, 32'd34); end
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL jr_result got=%h exp=%h", Result, 32'd0); end
        drive(rt(6'h09, 5'd0), 32'h0000_0800, 32'd0, 32'd0, 32'h0000_0040);
        total++;
        if (newPC !== 32'h0000_0800) begin bad++; $display("FAIL jalr_pc got=%h exp=%h", newPC, 32'h0000_0800); end
        total++;
        if (Result !== 32'h0000_0040) begin bad++; $display("FAIL jalr_result got=%h exp=%h", Result, 32'h0000_0040); end
    endtask

    task automatic test_branch;
        logic [5:0]  op  [6] = '{6'h04, 6'h05, 6'h06, 6'h06, 6'h07, 6'h07};
        logic [31:0] a   [6] = '{32'd5, 32'd5, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] exp [6] = '{32'h0000_00FC, 32'h0000_0100, 32'h0000_00FC,
                                 32'h0000_0100, 32'h0000_00FC, 32'h0000_0100};
        for (int i = 0; i < 6; i++) begin
            drive(it(op[i], 16'hFFFF), a[i], 32'd5, 32'hFFFF_FFFF, 32'h0000_0100);
            total++;
            if (newPC !== exp[i]) begin bad++; $display("FAIL branch_%0d got=%h exp=%h", i, newPC, exp[i]); end
        end
        drive(it(6'h05, 16'h0010), 32'd1, 32'd2, 32'h0000_0010, 32'h0000_0100);
        total++;
        if (newPC !== 32'h0000_0140) begin bad++; $display("FAIL bne_taken got=%h exp=%h", newPC, 32'h0000_0140); end
        total++;
        if (Result !== 32'd0) begin bad++; $display("FAIL branch_result got=%h exp=%h", Result, 32'd0); end
    endtask

    initial begin
        RST = 1'b0; Ins = 32'd0; Rdata1 = 32'd0; Rdata2 = 32'd0; Ed32 = 32'd0; nextPC = 32'd0;
        @(negedge CLK);
        test_reset();
        test_arith();
        test_compare();
        test_shift();
        test_itype();
        test_hilo();
        test_jumps();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
